// File: rtl/cell_ctrl.sv
// Ping-pong bank scheduler: hands the frame writer a free bank/address and starts the cell fetcher on full banks.
// rd_start_o two cycles after the last write; wr_ready_o low while both banks are FULL/READING (writes then dropped, err_o set).
module cell_ctrl #(
    parameter int CELL_NUM    = 1200,
    parameter int CELL_ADDR_W = $clog2(CELL_NUM)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_cell_valid_i,
    output logic                   wr_ready_o,
    output logic                   wr_bank_o,
    output logic [CELL_ADDR_W-1:0] wr_cell_addr_o,
    output logic                   rd_start_o,
    output logic                   rd_bank_o,
    input  logic                   rd_hs_i,
    output logic                   frame_done_o,
    output logic [1:0]             bank_full_o,
    output logic                   err_o
);

    typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_READING} bank_st_e;
    typedef enum logic [1:0] {RD_IDLE, RD_START, RD_RUN} rd_st_e;

    localparam logic [CELL_ADDR_W-1:0] LAST = CELL_ADDR_W'(CELL_NUM - 1);

    bank_st_e               bank_st_q [2];
    bank_st_e               bank_st_d [2];
    rd_st_e                 rd_st_q, rd_st_d;
    logic                   wr_bank_q, wr_bank_d;
    logic [CELL_ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic                   rd_bank_q, rd_bank_d;
    logic [CELL_ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
    logic                   frame_done_q, frame_done_d;
    logic                   err_q, err_d;

    logic wr_rdy, wr_acc, wr_last, rd_acc, rd_last;

    always_comb begin
        wr_rdy  = (bank_st_q[wr_bank_q] == B_EMPTY) || (bank_st_q[wr_bank_q] == B_FILLING);
        wr_acc  = wr_cell_valid_i && wr_rdy;
        wr_last = wr_acc && (wr_addr_q == LAST);
        rd_acc  = rd_hs_i && (rd_st_q == RD_RUN);
        rd_last = rd_acc && (rd_cnt_q == LAST);
    end

    always_comb begin
        wr_bank_d = wr_bank_q;
        wr_addr_d = wr_addr_q;
        if (wr_acc) begin
            if (wr_last) begin
                wr_addr_d = '0;
                wr_bank_d = ~wr_bank_q;
            end else begin
                wr_addr_d = wr_addr_q + 1'b1;
            end
        end
    end

    // Writer and reader never own the same bank, so the updates below cannot collide.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            bank_st_d[i] = bank_st_q[i];
            if (wr_acc && (wr_bank_q == 1'(i)))
                bank_st_d[i] = wr_last ? B_FULL : B_FILLING;
            if ((rd_st_q == RD_START) && (rd_bank_q == 1'(i)))
                bank_st_d[i] = B_READING;
            if (rd_last && (rd_bank_q == 1'(i)))
                bank_st_d[i] = B_EMPTY;
        end
    end

    always_comb begin
        rd_st_d   = rd_st_q;
        rd_cnt_d  = rd_cnt_q;
        rd_bank_d = rd_bank_q;
        case (rd_st_q)
            RD_IDLE: begin
                if (bank_st_q[rd_bank_q] == B_FULL)
                    rd_st_d = RD_START;
            end
            RD_START: begin
                rd_cnt_d = '0;
                rd_st_d  = RD_RUN;
            end
            RD_RUN: begin
                if (rd_acc) begin
                    if (rd_last) begin
                        rd_cnt_d  = '0;
                        rd_bank_d = ~rd_bank_q;
                        rd_st_d   = RD_IDLE;
                    end else begin
                        rd_cnt_d = rd_cnt_q + 1'b1;
                    end
                end
            end
            default: rd_st_d = RD_IDLE;
        endcase
    end

    always_comb begin
        frame_done_d = rd_last;
        err_d        = err_q || (wr_cell_valid_i && !wr_rdy) || (rd_hs_i && (rd_st_q != RD_RUN));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_st_q[0] <= B_EMPTY;
            bank_st_q[1] <= B_EMPTY;
            rd_st_q      <= RD_IDLE;
            wr_bank_q    <= 1'b0;
            wr_addr_q    <= '0;
            rd_bank_q    <= 1'b0;
            rd_cnt_q     <= '0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            bank_st_q[0] <= bank_st_d[0];
            bank_st_q[1] <= bank_st_d[1];
            rd_st_q      <= rd_st_d;
            wr_bank_q    <= wr_bank_d;
            wr_addr_q    <= wr_addr_d;
            rd_bank_q    <= rd_bank_d;
            rd_cnt_q     <= rd_cnt_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
        end
    end

    assign wr_ready_o     = wr_rdy;
    assign wr_bank_o      = wr_bank_q;
    assign wr_cell_addr_o = wr_addr_q;
    assign rd_start_o     = (rd_st_q == RD_START);
    assign rd_bank_o      = rd_bank_q;
    assign frame_done_o   = frame_done_q;
    assign err_o          = err_q;
    assign bank_full_o[0] = (bank_st_q[0] == B_FULL) || (bank_st_q[0] == B_READING);
    assign bank_full_o[1] = (bank_st_q[1] == B_FULL) || (bank_st_q[1] == B_READING);

endmodule

// File: tb/tb_cell_ctrl.sv
// Bench for cell_ctrl with a 4-cell bank: directed vector table, then random traffic against a frame-counting model.
module tb_cell_ctrl;

    localparam int N = 4;
    localparam int AW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_cell_valid_i;
    logic          wr_ready_o;
    logic          wr_bank_o;
    logic [AW-1:0] wr_cell_addr_o;
    logic          rd_start_o;
    logic          rd_bank_o;
    logic          rd_hs_i;
    logic          frame_done_o;
    logic [1:0]    bank_full_o;
    logic          err_o;

    cell_ctrl #(.CELL_NUM(N)) dut (
        .clk             (clk),
        .rst             (rst),
        .wr_cell_valid_i (wr_cell_valid_i),
        .wr_ready_o      (wr_ready_o),
        .wr_bank_o       (wr_bank_o),
        .wr_cell_addr_o  (wr_cell_addr_o),
        .rd_start_o      (rd_start_o),
        .rd_bank_o       (rd_bank_o),
        .rd_hs_i         (rd_hs_i),
        .frame_done_o    (frame_done_o),
        .bank_full_o     (bank_full_o),
        .err_o           (err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        bit       rst, wv, hs;
        bit       rdy, wb;
        int       wa;
        bit       st, rb, fd;
        bit [1:0] bf;
        bit       err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit r, bit wv, bit hs, bit rdy, bit wb, int wa,
                                bit st, bit rb, bit fd, bit [1:0] bf, bit err);
        vec_t v;
        v.rst = r; v.wv = wv; v.hs = hs; v.rdy = rdy; v.wb = wb; v.wa = wa;
        v.st = st; v.rb = rb; v.fd = fd; v.bf = bf; v.err = err;
        return v;
    endfunction

    // Frame-level model: counts of completed frames written/delivered decide bank ownership.
    int fw, fd, wcnt, rcnt;
    bit rd_active, start_now, fdone, merr;

    task automatic model_reset();
        fw = 0; fd = 0; wcnt = 0; rcnt = 0;
        rd_active = 0; start_now = 0; fdone = 0; merr = 0;
    endtask

    function automatic bit m_rdy();
        return (fw - fd) < 2;
    endfunction

    function automatic bit [1:0] m_bf();
        bit [1:0] b;
        b = 2'b00;
        if (fw - fd == 2) b = 2'b11;
        else if (fw - fd == 1) b[fd % 2] = 1'b1;
        return b;
    endfunction

    task automatic model_step(input bit r, input bit wv, input bit hs);
        bit rdy, run, idle, pend;
        if (r) begin
            model_reset();
            return;
        end
        rdy  = m_rdy();
        run  = rd_active && !start_now;
        idle = !rd_active;
        pend = fw > fd;
        if (wv && !rdy) merr = 1;
        if (hs && !run) merr = 1;
        fdone = 0;
        if (start_now) start_now = 0;
        else if (idle && pend) begin
            start_now = 1;
            rd_active = 1;
        end
        if (hs && run) begin
            rcnt++;
            if (rcnt == N) begin
                rcnt = 0; fd++; rd_active = 0; fdone = 1;
            end
        end
        if (wv && rdy) begin
            wcnt++;
            if (wcnt == N) begin
                wcnt = 0; fw++;
            end
        end
    endtask

    initial begin
        rst = 1'b1; wr_cell_valid_i = 1'b0; rd_hs_i = 1'b0;

        //          rst wv hs  rdy wb wa st rb fd bf     err
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0));  // 0 reset
        vecs.push_back(mk(0, 1, 0, 1, 0, 1, 0, 0, 0, 2'b00, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 2, 0, 0, 0, 2'b00, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 3, 0, 0, 0, 2'b00, 0));
        vecs.push_back(mk(0, 1, 0, 1, 1, 0, 0, 0, 0, 2'b01, 0));  // 4 last write bank0
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 1, 0, 0, 2'b01, 0));  // start pulse
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 2'b01, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0, 0, 2'b01, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0, 0, 2'b01, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0, 0, 2'b01, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0, 1, 1, 2'b00, 0));  // 10 frame done
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 1, 0, 2'b00, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0, 1, 0, 2'b00, 1));  // hs while idle
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0));  // 13 reset
        vecs.push_back(mk(0, 1, 0, 1, 0, 1, 0, 0, 0, 2'b00, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 2, 0, 0, 0, 2'b00, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 3, 0, 0, 0, 2'b00, 0));
        vecs.push_back(mk(0, 1, 0, 1, 1, 0, 0, 0, 0, 2'b01, 0));
        vecs.push_back(mk(0, 1, 0, 1, 1, 1, 1, 0, 0, 2'b01, 0));
        vecs.push_back(mk(0, 1, 0, 1, 1, 2, 0, 0, 0, 2'b01, 0));
        vecs.push_back(mk(0, 1, 0, 1, 1, 3, 0, 0, 0, 2'b01, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b11, 0));  // 21 both full
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b11, 1));  // dropped write
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b11, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b11, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b11, 1));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 1, 1, 2'b10, 1));  // 26 bank0 drained
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1, 0, 2'b10, 1));  // back-to-back start
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 0, 2'b10, 1));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0));  // 29 reset
        vecs.push_back(mk(0, 1, 0, 1, 0, 1, 0, 0, 0, 2'b00, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 2, 0, 0, 0, 2'b00, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 3, 0, 0, 0, 2'b00, 0));
        vecs.push_back(mk(0, 1, 0, 1, 1, 0, 0, 0, 0, 2'b01, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 1, 0, 0, 2'b01, 0));
        vecs.push_back(mk(0, 1, 0, 1, 1, 1, 0, 0, 0, 2'b01, 0));
        vecs.push_back(mk(0, 1, 1, 1, 1, 2, 0, 0, 0, 2'b01, 0));
        vecs.push_back(mk(0, 1, 1, 1, 1, 3, 0, 0, 0, 2'b01, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 3, 0, 0, 0, 2'b01, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0, 1, 1, 2'b10, 0));  // 39 simultaneous completion
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1, 0, 2'b10, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1, 0, 2'b10, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 1, 0, 2'b10, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 1, 0, 2'b10, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0));  // 44 reset mid-frame
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 1));  // hs in idle

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; wr_cell_valid_i = vecs[i].wv; rd_hs_i = vecs[i].hs;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_wr_ready", i), int'(wr_ready_o), int'(vecs[i].rdy));
            chk($sformatf("v%0d_wr_bank", i), int'(wr_bank_o), int'(vecs[i].wb));
            chk($sformatf("v%0d_wr_addr", i), int'(wr_cell_addr_o), vecs[i].wa);
            chk($sformatf("v%0d_rd_start", i), int'(rd_start_o), int'(vecs[i].st));
            chk($sformatf("v%0d_rd_bank", i), int'(rd_bank_o), int'(vecs[i].rb));
            chk($sformatf("v%0d_frame_done", i), int'(frame_done_o), int'(vecs[i].fd));
            chk($sformatf("v%0d_bank_full", i), int'(bank_full_o), int'(vecs[i].bf));
            chk($sformatf("v%0d_err", i), int'(err_o), int'(vecs[i].err));
        end

        model_reset();
        rst = 1'b1; wr_cell_valid_i = 1'b0; rd_hs_i = 1'b0;
        @(posedge clk);
        #1;
        for (int c = 0; c < 3000; c++) begin
            bit r, wv, hs;
            r  = ($urandom_range(0, 399) == 0);
            wv = ($urandom_range(0, 99) < 65);
            if (rd_active && !start_now) hs = ($urandom_range(0, 99) < 60);
            else                         hs = ($urandom_range(0, 99) < 2);
            rst = r; wr_cell_valid_i = wv; rd_hs_i = hs;
            model_step(r, wv, hs);
            @(posedge clk);
            #1;
            chk($sformatf("r%0d_wr_ready", c), int'(wr_ready_o), int'(m_rdy()));
            chk($sformatf("r%0d_wr_bank", c), int'(wr_bank_o), fw % 2);
            chk($sformatf("r%0d_wr_addr", c), int'(wr_cell_addr_o), wcnt);
            chk($sformatf("r%0d_rd_start", c), int'(rd_start_o), int'(start_now));
            chk($sformatf("r%0d_rd_bank", c), int'(rd_bank_o), fd % 2);
            chk($sformatf("r%0d_frame_done", c), int'(frame_done_o), int'(fdone));
            chk($sformatf("r%0d_bank_full", c), int'(bank_full_o), int'(m_bf()));
            chk($sformatf("r%0d_err", c), int'(err_o), int'(merr));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
